instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
Parametrised instruction memory for the MIPS fetch stage. Fetch is synchronous (1-cycle latency) with a stall hold, and bad fetch addresses are flagged. A byte-serial loader FSM assembles bytes into words and writes the program sequentially from word 0. The block sits between the PC/fetch logic and the IF/ID pipeline register, with the loader driven by the testbench or a host/UART front end.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be word-aligned.
BIG_ENDIAN, 1, 1: first loaded byte goes to bits [31:24]; 0: first byte goes to bits [7:0].

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high
fetch_req  in  1  fetch request this cycle
fetch_addr  in  32  byte address of the instruction
fetch_stall  in  1  hold fetch outputs, ignore fetch_req
fetch_valid  out  1  fetch_data/fetch_err valid
fetch_data  out  32  instruction word
fetch_err  out  1  misaligned or out-of-range fetch
load_start  in  1  begin program load (accepted in IDLE/DONE only)
load_byte_valid  in  1  load_byte is valid
load_byte  in  8  program byte
load_last  in  1  qualifies the final byte of the image
load_ready  out  1  loader accepts a byte this cycle
load_busy  out  1  FSM in LOAD
load_done  out  1  FSM in DONE
load_count  out  DEPTH_LOG2+1  words written by the current/last load

Behaviour:
- Reset: fetch_valid=0, fetch_data=0, fetch_err=0, load_ready=0, load_busy=0, load_done=0, load_count=0, FSM=IDLE, byte index=0. RAM contents are not cleared.
- FSM states are IDLE, LOAD and DONE.
  - IDLE/DONE -> LOAD on load_start. On entry: word pointer=0, byte index=0, load_count=0, load_done=0.
  - In LOAD, load_start is ignored.
- Loader:
  - load_ready=1 only in LOAD. A byte is accepted when load_byte_valid && load_ready.
  - Bytes are shifted into a 32-bit assembly register, ordered per BIG_ENDIAN.
  - When the 4th byte is accepted in cycle N, the word is written to RAM[ptr] at the cycle-N edge, and ptr and load_count increment.
  - load_last on an accepted byte writes the (possibly partial) word and goes to DONE. Unfilled byte lanes are 0.
  - A load_last that lands on a word boundary writes exactly that word; no extra zero word is written.
  - When load_count reaches DEPTH, the FSM goes to DONE automatically. Any further bytes are not accepted because load_ready=0.
- Fetch (not in LOAD, not stalled):
  - A fetch_req in cycle N produces, in cycle N+1, fetch_valid=1 and fetch_data=RAM[(fetch_addr-BASE_ADDR)>>2].
  - No fetch_req in cycle N gives fetch_valid=0 in cycle N+1.
  - fetch_err=1 and fetch_data=32'h0000_0000 (NOP) when any of these hold: fetch_addr[1:0]!=0; fetch_addr<BASE_ADDR; (fetch_addr-BASE_ADDR)>>2 >= DEPTH. Index arithmetic is 32-bit unsigned, and the range check is done before truncation to DEPTH_LOG2 bits.
- fetch_stall=1: fetch_valid, fetch_data and fetch_err hold their values; fetch_req is ignored (dropped, not queued).
- While load_busy: fetch_req is ignored and fetch_valid is forced to 0 next cycle. There is no RAM read/write collision.
- Stall and load interaction: load_busy takes precedence; fetch_valid is cleared even if fetch_stall is high.
- First fetch after DONE observes all loaded words, with no forwarding needed.
- Reset mid-load: FSM returns to IDLE and load_count=0. Words already written stay in RAM. The partial assembly register is discarded.

Test Plan:
- Load bytes 8'h20,8'h08,8'h00,8'h05 (last), BIG_ENDIAN=1 -> RAM[0]=32'h2008_0005, load_count=1, load_done=1. Then fetch_req with addr 0 -> next cycle fetch_valid=1, fetch_data=32'h2008_0005, fetch_err=0.
- Load 6 bytes 01..06 with load_last on byte 06 -> RAM[0]=32'h0102_0304, RAM[1]=32'h0506_0000, load_count=2. Repeat with BIG_ENDIAN=0 -> RAM[0]=32'h0403_0201, RAM[1]=32'h0000_0605.
- Fetch addr 32'h0000_0002 -> fetch_err=1, fetch_data=0. Fetch addr 4*DEPTH -> fetch_err=1. With BASE_ADDR=32'h0040_0000, fetch addr 32'h003F_FFFC -> fetch_err=1, and addr 32'h0040_0004 -> RAM[1].
- Fetch addr 0 in cycle N, fetch_stall=1 in N+1..N+3 with fetch_req to addr 4 -> outputs hold RAM[0] through N+3. Stall released -> next fetch_req to addr 4 returns RAM[1].
- Stream 4*DEPTH+4 bytes without load_last -> DONE after word DEPTH-1, load_count=DEPTH, load_ready=0 for the remaining bytes, and RAM[0] is not overwritten.
- Assert reset after 5 bytes of a load -> IDLE, load_count=0, RAM[0] keeps its new value, and fetch_req with addr 0 one cycle after reset deassertion returns valid data.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Instruction memory for the MIPS fetch stage, with 1-cycle synchronous fetch.
// A byte-serial loader packs incoming bytes into words and writes them from word 0.
module instr_mem_loadable #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  fetch_req_i,
    input  logic [31:0]           fetch_addr_i,
    input  logic                  fetch_stall_i,
    output logic                  fetch_valid_o,
    output logic [31:0]           fetch_data_o,
    output logic                  fetch_err_o,
    input  logic                  load_start_i,
    input  logic                  load_byte_valid_i,
    input  logic [7:0]            load_byte_i,
    input  logic                  load_last_i,
    output logic                  load_ready_o,
    output logic                  load_busy_o,
    output logic                  load_done_o,
    output logic [DEPTH_LOG2:0]   load_count_o
);

    localparam int unsigned         DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [31:0]         DEPTH_W  = 32'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LAST_CNT = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic                  mem_we;

    logic [31:0]           asm_shift;
    logic [31:0]           asm_word;
    logic [4:0]            pad_bits;

    logic                  fetch_valid_q;
    logic [31:0]           fetch_data_q;
    logic                  fetch_err_q;

    logic                  fetch_borrow;
    logic [31:0]           fetch_off;
    logic                  fetch_bad;
    logic [DEPTH_LOG2-1:0] fetch_idx;

    // Shifting the new byte in, then padding by the unfilled lanes, also flushes stale bytes.
    always_comb begin
        pad_bits = {2'd3 - byte_idx_q, 3'b000};
        if (BIG_ENDIAN) begin
            asm_shift = {asm_q[23:0], load_byte_i};
            asm_word  = asm_shift << pad_bits;
        end else begin
            asm_shift = {load_byte_i, asm_q[31:8]};
            asm_word  = asm_shift >> pad_bits;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (load_start_i) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    byte_idx_d = 2'd0;
                    asm_d      = 32'h0;
                end
            end
            LOAD: begin
                if (load_byte_valid_i) begin
                    asm_d      = asm_shift;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3 || load_last_i) begin
                        mem_we     = 1'b1;
                        count_d    = count_q + 1'b1;
                        byte_idx_d = 2'd0;
                        asm_d      = 32'h0;
                        if (load_last_i || count_q == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            byte_idx_q <= 2'd0;
            asm_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we && !reset_i) begin
            mem[count_q[DEPTH_LOG2-1:0]] <= asm_word;
        end
    end

    // The borrow of a 33-bit subtract flags addresses below the base.
    always_comb begin
        {fetch_borrow, fetch_off} = {1'b0, fetch_addr_i} - {1'b0, BASE_ADDR};
        fetch_bad = (fetch_addr_i[1:0] != 2'b00) || fetch_borrow || ((fetch_off >> 2) >= DEPTH_W);
        fetch_idx = fetch_off[DEPTH_LOG2+1:2];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= 32'h0;
            fetch_err_q   <= 1'b0;
        end else if (state_q == LOAD) begin
            fetch_valid_q <= 1'b0;
        end else if (!fetch_stall_i) begin
            fetch_valid_q <= fetch_req_i;
            if (fetch_req_i) begin
                fetch_err_q  <= fetch_bad;
                fetch_data_q <= fetch_bad ? 32'h0 : mem[fetch_idx];
            end
        end
    end

    assign fetch_valid_o = fetch_valid_q;
    assign fetch_data_o  = fetch_data_q;
    assign fetch_err_o   = fetch_err_q;
    assign load_ready_o  = (state_q == LOAD);
    assign load_busy_o   = (state_q == LOAD);
    assign load_done_o   = (state_q == DONE);
    assign load_count_o  = count_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: three instances share one stimulus stream
// to cover big-endian, little-endian and non-zero base address variants together.
module tb_instr_mem_loadable;

    localparam int DL2 = 3;

    logic clk = 1'b0;
    logic reset;
    logic fetchReq;
    logic [31:0] fetchAddr;
    logic fetchStall;
    logic loadStart;
    logic loadByteValid;
    logic [7:0] loadByte;
    logic loadLast;

    logic aValid, aErr, aReady, aBusy, aDone;
    logic [31:0] aData;
    logic [DL2:0] aCount;
    logic bValid, bErr, bReady, bBusy, bDone;
    logic [31:0] bData;
    logic [DL2:0] bCount;
    logic cValid, cErr, cReady, cBusy, cDone;
    logic [31:0] cData;
    logic [DL2:0] cCount;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    instr_mem_loadable #(.DEPTH_LOG2(DL2), .BASE_ADDR(32'h0000_0000), .BIG_ENDIAN(1'b1)) dutA (
        .clk_i(clk), .reset_i(reset),
        .fetch_req_i(fetchReq), .fetch_addr_i(fetchAddr), .fetch_stall_i(fetchStall),
        .fetch_valid_o(aValid), .fetch_data_o(aData), .fetch_err_o(aErr),
        .load_start_i(loadStart), .load_byte_valid_i(loadByteValid), .load_byte_i(loadByte),
        .load_last_i(loadLast), .load_ready_o(aReady), .load_busy_o(aBusy),
        .load_done_o(aDone), .load_count_o(aCount)
    );

    instr_mem_loadable #(.DEPTH_LOG2(DL2), .BASE_ADDR(32'h0000_0000), .BIG_ENDIAN(1'b0)) dutB (
        .clk_i(clk), .reset_i(reset),
        .fetch_req_i(fetchReq), .fetch_addr_i(fetchAddr), .fetch_stall_i(fetchStall),
        .fetch_valid_o(bValid), .fetch_data_o(bData), .fetch_err_o(bErr),
        .load_start_i(loadStart), .load_byte_valid_i(loadByteValid), .load_byte_i(loadByte),
        .load_last_i(loadLast), .load_ready_o(bReady), .load_busy_o(bBusy),
        .load_done_o(bDone), .load_count_o(bCount)
    );

    instr_mem_loadable #(.DEPTH_LOG2(DL2), .BASE_ADDR(32'h0040_0000), .BIG_ENDIAN(1'b1)) dutC (
        .clk_i(clk), .reset_i(reset),
        .fetch_req_i(fetchReq), .fetch_addr_i(fetchAddr), .fetch_stall_i(fetchStall),
        .fetch_valid_o(cValid), .fetch_data_o(cData), .fetch_err_o(cErr),
        .load_start_i(loadStart), .load_byte_valid_i(loadByteValid), .load_byte_i(loadByte),
        .load_last_i(loadLast), .load_ready_o(cReady), .load_busy_o(cBusy),
        .load_done_o(cDone), .load_count_o(cCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic stall);
        fetchReq   = req;
        fetchAddr  = addr;
        fetchStall = stall;
        @(negedge clk);
    endtask

    task automatic startLoad();
        loadStart = 1'b1;
        @(negedge clk);
        loadStart = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic last);
        loadByteValid = 1'b1;
        loadByte      = b;
        loadLast      = last;
        @(negedge clk);
        loadByteValid = 1'b0;
        loadLast      = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        fetchReq = 1'b0;
        fetchAddr = 32'h0;
        fetchStall = 1'b0;
        loadStart = 1'b0;
        loadByteValid = 1'b0;
        loadByte = 8'h00;
        loadLast = 1'b0;
        @(negedge clk);
        @(negedge clk);

        checkOutput("rst_valid", aValid, 32'd0);
        checkOutput("rst_data", aData, 32'd0);
        checkOutput("rst_err", aErr, 32'd0);
        checkOutput("rst_ready", aReady, 32'd0);
        checkOutput("rst_busy", aBusy, 32'd0);
        checkOutput("rst_done", aDone, 32'd0);
        checkOutput("rst_count", aCount, 32'd0);
        reset = 1'b0;

        // Single full word, load_last on a word boundary
        startLoad();
        checkOutput("l1_ready", aReady, 32'd1);
        checkOutput("l1_busy", aBusy, 32'd1);
        checkOutput("l1_count0", aCount, 32'd0);
        sendByte(8'h20, 1'b0);
        sendByte(8'h08, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h05, 1'b1);
        checkOutput("l1_done", aDone, 32'd1);
        checkOutput("l1_busy_off", aBusy, 32'd0);
        checkOutput("l1_count", aCount, 32'd1);
        checkOutput("l1_ready_off", aReady, 32'd0);
        checkOutput("l1_cOtherDone", cDone, 32'd1);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("f0_valid", aValid, 32'd1);
        checkOutput("f0_data_be", aData, 32'h2008_0005);
        checkOutput("f0_err", aErr, 32'd0);
        checkOutput("f0_data_le", bData, 32'h0500_0820);
        checkOutput("f0_below_base_err", cErr, 32'd1);
        checkOutput("f0_below_base_data", cData, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("noreq_valid", aValid, 32'd0);

        // Six bytes, partial second word
        startLoad();
        checkOutput("l2_done_clr", aDone, 32'd0);
        for (int i = 1; i <= 6; i++) sendByte(8'(i), i == 6);
        checkOutput("l2_count_be", aCount, 32'd2);
        checkOutput("l2_count_le", bCount, 32'd2);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("l2_w0_be", aData, 32'h0102_0304);
        checkOutput("l2_w0_le", bData, 32'h0403_0201);
        applyStimulus(1'b1, 32'h4, 1'b0);
        checkOutput("l2_w1_be", aData, 32'h0506_0000);
        checkOutput("l2_w1_le", bData, 32'h0000_0605);

        // Bad addresses
        applyStimulus(1'b1, 32'h2, 1'b0);
        checkOutput("mis_valid", aValid, 32'd1);
        checkOutput("mis_err", aErr, 32'd1);
        checkOutput("mis_data", aData, 32'h0);
        applyStimulus(1'b1, 32'd32, 1'b0);
        checkOutput("oor_err", aErr, 32'd1);
        applyStimulus(1'b1, 32'd28, 1'b0);
        checkOutput("top_word_err", aErr, 32'd0);
        checkOutput("c_low_err", cErr, 32'd1);
        applyStimulus(1'b1, 32'h003F_FFFC, 1'b0);
        checkOutput("c_under_err", cErr, 32'd1);
        checkOutput("c_under_data", cData, 32'h0);
        applyStimulus(1'b1, 32'h0040_0004, 1'b0);
        checkOutput("c_w1_err", cErr, 32'd0);
        checkOutput("c_w1_data", cData, 32'h0506_0000);
        checkOutput("a_high_err", aErr, 32'd1);

        // Stall holds outputs and drops requests
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("st_pre_data", aData, 32'h0102_0304);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h4, 1'b1);
            checkOutput("st_hold_valid", aValid, 32'd1);
            checkOutput("st_hold_data", aData, 32'h0102_0304);
        end
        applyStimulus(1'b1, 32'h4, 1'b0);
        checkOutput("st_rel_data", aData, 32'h0506_0000);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("st_rel_idle", aValid, 32'd0);

        // Loading overrides a held stall
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("bp_valid", aValid, 32'd1);
        loadStart = 1'b1;
        applyStimulus(1'b1, 32'h4, 1'b1);
        loadStart = 1'b0;
        checkOutput("bp_stall_hold", aValid, 32'd1);
        applyStimulus(1'b1, 32'h4, 1'b1);
        checkOutput("bp_busy", aBusy, 32'd1);
        checkOutput("bp_valid_clr", aValid, 32'd0);

        // Overflow: stream past capacity without load_last
        fetchReq = 1'b0;
        fetchStall = 1'b0;
        for (int i = 0; i < 36; i++) begin
            loadByteValid = 1'b1;
            loadByte = 8'(16 + i);
            loadLast = 1'b0;
            if (i == 31) checkOutput("ov_ready_last", aReady, 32'd1);
            if (i == 32) checkOutput("ov_ready_full", aReady, 32'd0);
            @(negedge clk);
        end
        loadByteValid = 1'b0;
        checkOutput("ov_count", aCount, 32'd8);
        checkOutput("ov_done", aDone, 32'd1);
        checkOutput("ov_count_le", bCount, 32'd8);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("ov_w0_be", aData, 32'h1011_1213);
        checkOutput("ov_w0_le", bData, 32'h1312_1110);
        applyStimulus(1'b1, 32'd28, 1'b0);
        checkOutput("ov_w7_be", aData, 32'h2C2D_2E2F);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Reset in the middle of a load
        startLoad();
        sendByte(8'hAA, 1'b0);
        sendByte(8'hBB, 1'b0);
        sendByte(8'hCC, 1'b0);
        sendByte(8'hDD, 1'b0);
        sendByte(8'hEE, 1'b0);
        checkOutput("ml_count_pre", aCount, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("ml_count", aCount, 32'd0);
        checkOutput("ml_busy", aBusy, 32'd0);
        checkOutput("ml_done", aDone, 32'd0);
        checkOutput("ml_ready", aReady, 32'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("ml_f_valid", aValid, 32'd1);
        checkOutput("ml_f_err", aErr, 32'd0);
        checkOutput("ml_f_be", aData, 32'hAABB_CCDD);
        checkOutput("ml_f_le", bData, 32'hDDCC_BBAA);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
